// File: rtl/execute_stage_pkg.sv
// Shared definitions for the execute stage: widths, ALU and branch codes,
// FSM encodings and the captured-control record used by the conv path.
package execute_stage_pkg;

   localparam int INT32      = 32;
   localparam int INT8       = 8;
   localparam int DEF_LENGTH = 16;
   localparam int DEF_CHUNK  = 4;

   localparam logic [3:0] ALU_PASS = 4'd0;
   localparam logic [3:0] ALU_ADD  = 4'd1;
   localparam logic [3:0] ALU_SUB  = 4'd2;
   localparam logic [3:0] ALU_AND  = 4'd3;
   localparam logic [3:0] ALU_OR   = 4'd4;
   localparam logic [3:0] ALU_XOR  = 4'd5;
   localparam logic [3:0] ALU_SHL  = 4'd6;
   localparam logic [3:0] ALU_SHR  = 4'd7;
   localparam logic [3:0] ALU_VADD = 4'd8;
   localparam logic [3:0] ALU_VSUB = 4'd9;
   localparam logic [3:0] ALU_VMAX = 4'd10;

   localparam logic [1:0] B_NONE   = 2'b00;
   localparam logic [1:0] B_ALWAYS = 2'b01;
   localparam logic [1:0] B_Z      = 2'b10;
   localparam logic [1:0] B_N      = 2'b11;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_CONV = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   typedef struct packed {
      logic [4:0] opcode;
      logic [4:0] rd;
      logic [2:0] strd;
      logic       ldr;
      logic [1:0] wb;
      logic       mem_rw;
      logic       mem_v;
      logic       setcc;
   } ctrl_t;

   function automatic logic [INT8-1:0] vmax8(input logic signed [INT8-1:0] a,
                                             input logic signed [INT8-1:0] b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/execute_stage_conv_mac.sv
// Combinational signed int8 multiply-sum over CHUNK lanes, sign-extended to XLEN.
module conv_mac_chunk
   import execute_stage_pkg::*;
#(
   parameter int XLEN  = INT32,
   parameter int CHUNK = DEF_CHUNK
) (
   input  logic [CHUNK*INT8-1:0]  a_i,
   input  logic [CHUNK*INT8-1:0]  b_i,
   output logic signed [XLEN-1:0] sum_o
);

   logic signed [XLEN-1:0] prod_ext [CHUNK];

   for (genvar g = 0; g < CHUNK; g++) begin : g_lane
      logic signed [2*INT8-1:0] prod;
      // 16-bit product never overflows: worst case is (-128)*(-128) = 16384
      assign prod        = $signed(a_i[g*INT8 +: INT8]) * $signed(b_i[g*INT8 +: INT8]);
      assign prod_ext[g] = XLEN'(prod);
   end

   always_comb begin
      sum_o = '0;
      for (int i = 0; i < CHUNK; i++) begin
         sum_o = sum_o + prod_ext[i];
      end
   end

endmodule

// File: rtl/execute_stage.sv
// Execute stage: scalar ALU, lane-wise int8 vector ops, multi-cycle int8 dot
// product, branch resolution against the NZ flags, registered Execute->Memory outputs.
module execute_stage
   import execute_stage_pkg::*;
#(
   parameter int XLEN   = INT32,
   parameter int LENGTH = DEF_LENGTH,
   parameter int CHUNK  = DEF_CHUNK
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [XLEN-1:0]        PC,
   input  logic [4:0]             opcode,
   input  logic [4:0]             rD,
   input  logic [XLEN-1:0]        rA_data,
   input  logic [XLEN-1:0]        rB_data,
   input  logic [LENGTH*INT8-1:0] vA_data,
   input  logic [LENGTH*INT8-1:0] vB_data,
   input  logic [2:0]             strd,
   input  logic                   ldr,
   input  logic [1:0]             b,
   input  logic [1:0]             wb,
   input  logic [3:0]             alu,
   input  logic                   setcc,
   input  logic                   mem_rw,
   input  logic                   mem_v,
   input  logic                   conv_en,
   output logic [XLEN-1:0]        out_PC,
   output logic [4:0]             out_opcode,
   output logic [4:0]             out_rD,
   output logic [2:0]             out_strd,
   output logic                   out_ldr,
   output logic [1:0]             out_wb,
   output logic                   out_mem_rw,
   output logic                   out_mem_v,
   output logic [XLEN-1:0]        out_result,
   output logic [LENGTH*INT8-1:0] out_vresult,
   output logic [XLEN-1:0]        out_store_data,
   output logic                   b_taken,
   output logic [XLEN-1:0]        b_target,
   output logic                   stall,
   output logic [1:0]             flags
);

   localparam int NCHUNK = LENGTH / CHUNK;
   localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam int CB     = CHUNK * INT8;
   localparam logic [CW-1:0] CHUNK_LAST = CW'(NCHUNK - 1);

   logic [1:0]             state_q, state_d;
   logic [CW-1:0]          chunk_q, chunk_d;
   logic signed [XLEN-1:0] acc_q, acc_d;
   logic [1:0]             flags_q, flags_d;

   logic [XLEN-1:0]        out_pc_q, out_pc_d;
   logic [4:0]             out_opcode_q, out_opcode_d;
   logic [4:0]             out_rd_q, out_rd_d;
   logic [2:0]             out_strd_q, out_strd_d;
   logic                   out_ldr_q, out_ldr_d;
   logic [1:0]             out_wb_q, out_wb_d;
   logic                   out_mem_rw_q, out_mem_rw_d;
   logic                   out_mem_v_q, out_mem_v_d;
   logic [XLEN-1:0]        out_result_q, out_result_d;
   logic [LENGTH*INT8-1:0] out_vresult_q, out_vresult_d;
   logic [XLEN-1:0]        out_store_q, out_store_d;

   // Conv operands captured at acceptance; upstream contents are ignored until IDLE
   logic [LENGTH*INT8-1:0] va_q, vb_q;
   logic [XLEN-1:0]        pc_q;
   ctrl_t                  ctrl_q, ctrl_in;

   logic [XLEN-1:0]        scalar_res;
   logic [LENGTH*INT8-1:0] vec_res;
   logic                   b_cond;
   int                     chunk_base;
   logic [CB-1:0]          mac_a, mac_b;
   logic signed [XLEN-1:0] mac_sum;

   assign ctrl_in = '{opcode: opcode, rd: rD, strd: strd, ldr: ldr, wb: wb,
                      mem_rw: mem_rw, mem_v: mem_v, setcc: setcc};

   always_comb begin : alu_comb
      logic signed [INT8-1:0] la;
      logic signed [INT8-1:0] lb;
      scalar_res = '0;
      vec_res    = '0;
      la         = '0;
      lb         = '0;
      case (alu)
         ALU_PASS: scalar_res = rB_data;
         ALU_ADD:  scalar_res = rA_data + rB_data;
         ALU_SUB:  scalar_res = rA_data - rB_data;
         ALU_AND:  scalar_res = rA_data & rB_data;
         ALU_OR:   scalar_res = rA_data | rB_data;
         ALU_XOR:  scalar_res = rA_data ^ rB_data;
         ALU_SHL:  scalar_res = rA_data << rB_data[4:0];
         ALU_SHR:  scalar_res = rA_data >> rB_data[4:0];
         default:  scalar_res = '0;
      endcase
      for (int i = 0; i < LENGTH; i++) begin
         la = vA_data[i*INT8 +: INT8];
         lb = vB_data[i*INT8 +: INT8];
         case (alu)
            ALU_VADD: vec_res[i*INT8 +: INT8] = la + lb;
            ALU_VSUB: vec_res[i*INT8 +: INT8] = la - lb;
            ALU_VMAX: vec_res[i*INT8 +: INT8] = vmax8(la, lb);
            default:  ;
         endcase
      end
   end

   always_comb begin
      case (b)
         B_ALWAYS: b_cond = 1'b1;
         B_Z:      b_cond = flags_q[0];
         B_N:      b_cond = flags_q[1];
         default:  b_cond = 1'b0;
      endcase
   end

   // Conv has priority over a branch decoded on the same instruction
   assign b_taken  = reset & (state_q == ST_IDLE) & ~conv_en & b_cond;
   assign b_target = PC + rB_data;
   assign stall    = reset & ((state_q != ST_IDLE) | conv_en);

   assign chunk_base = int'(chunk_q) * CB;
   assign mac_a      = va_q[chunk_base +: CB];
   assign mac_b      = vb_q[chunk_base +: CB];

   conv_mac_chunk #(
      .XLEN  (XLEN),
      .CHUNK (CHUNK)
   ) u_mac (
      .a_i   (mac_a),
      .b_i   (mac_b),
      .sum_o (mac_sum)
   );

   always_comb begin
      state_d       = state_q;
      chunk_d       = chunk_q;
      acc_d         = acc_q;
      flags_d       = flags_q;
      out_pc_d      = '0;
      out_opcode_d  = '0;
      out_rd_d      = '0;
      out_strd_d    = '0;
      out_ldr_d     = 1'b0;
      out_wb_d      = '0;
      out_mem_rw_d  = 1'b0;
      out_mem_v_d   = 1'b0;
      out_result_d  = '0;
      out_vresult_d = '0;
      out_store_d   = '0;
      case (state_q)
         ST_IDLE: begin
            if (conv_en) begin
               state_d = ST_CONV;
               chunk_d = '0;
               acc_d   = '0;
            end else begin
               out_pc_d      = PC;
               out_opcode_d  = opcode;
               out_rd_d      = rD;
               out_strd_d    = strd;
               out_ldr_d     = ldr;
               out_wb_d      = wb;
               out_mem_rw_d  = mem_rw;
               out_mem_v_d   = mem_v;
               out_result_d  = scalar_res;
               out_vresult_d = vec_res;
               out_store_d   = rB_data;
               if (setcc) begin
                  flags_d = {scalar_res[XLEN-1], scalar_res == '0};
               end
            end
         end
         ST_CONV: begin
            acc_d   = acc_q + mac_sum;
            chunk_d = chunk_q + CW'(1);
            if (chunk_q == CHUNK_LAST) begin
               state_d = ST_DONE;
               chunk_d = '0;
            end
         end
         ST_DONE: begin
            state_d      = ST_IDLE;
            out_pc_d     = pc_q;
            out_opcode_d = ctrl_q.opcode;
            out_rd_d     = ctrl_q.rd;
            out_strd_d   = ctrl_q.strd;
            out_ldr_d    = ctrl_q.ldr;
            out_wb_d     = ctrl_q.wb;
            out_mem_rw_d = ctrl_q.mem_rw;
            out_mem_v_d  = ctrl_q.mem_v;
            out_result_d = acc_q;
            if (ctrl_q.setcc) begin
               flags_d = {acc_q[XLEN-1], acc_q == '0};
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= ST_IDLE;
         chunk_q       <= '0;
         acc_q         <= '0;
         flags_q       <= '0;
         out_pc_q      <= '0;
         out_opcode_q  <= '0;
         out_rd_q      <= '0;
         out_strd_q    <= '0;
         out_ldr_q     <= 1'b0;
         out_wb_q      <= '0;
         out_mem_rw_q  <= 1'b0;
         out_mem_v_q   <= 1'b0;
         out_result_q  <= '0;
         out_vresult_q <= '0;
         out_store_q   <= '0;
      end else begin
         state_q       <= state_d;
         chunk_q       <= chunk_d;
         acc_q         <= acc_d;
         flags_q       <= flags_d;
         out_pc_q      <= out_pc_d;
         out_opcode_q  <= out_opcode_d;
         out_rd_q      <= out_rd_d;
         out_strd_q    <= out_strd_d;
         out_ldr_q     <= out_ldr_d;
         out_wb_q      <= out_wb_d;
         out_mem_rw_q  <= out_mem_rw_d;
         out_mem_v_q   <= out_mem_v_d;
         out_result_q  <= out_result_d;
         out_vresult_q <= out_vresult_d;
         out_store_q   <= out_store_d;
      end
   end

   always_ff @(posedge clk) begin
      if (state_q == ST_IDLE && conv_en) begin
         va_q   <= vA_data;
         vb_q   <= vB_data;
         pc_q   <= PC;
         ctrl_q <= ctrl_in;
      end
   end

   assign out_PC         = out_pc_q;
   assign out_opcode     = out_opcode_q;
   assign out_rD         = out_rd_q;
   assign out_strd       = out_strd_q;
   assign out_ldr        = out_ldr_q;
   assign out_wb         = out_wb_q;
   assign out_mem_rw     = out_mem_rw_q;
   assign out_mem_v      = out_mem_v_q;
   assign out_result     = out_result_q;
   assign out_vresult    = out_vresult_q;
   assign out_store_data = out_store_q;
   assign flags          = flags_q;

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage: reset, scalar/vector ALU, branches, conv and reset abort.
module tb_execute_stage;

   logic         clk;
   logic         rst_n;
   logic [31:0]  PC, rA, rB;
   logic [4:0]   opcode, rD;
   logic [127:0] vA, vB;
   logic [2:0]   strd;
   logic         ldr, setcc, mem_rw, mem_v, conv_en;
   logic [1:0]   b, wb;
   logic [3:0]   alu;

   logic [31:0]  out_PC, out_result, out_store_data, b_target;
   logic [4:0]   out_opcode, out_rD;
   logic [2:0]   out_strd;
   logic         out_ldr, out_mem_rw, out_mem_v, b_taken, stall;
   logic [1:0]   out_wb, flags;
   logic [127:0] out_vresult;

   int n_tests = 0;
   int n_fail  = 0;

   execute_stage dut (
      .clk(clk), .reset(rst_n), .PC(PC), .opcode(opcode), .rD(rD),
      .rA_data(rA), .rB_data(rB), .vA_data(vA), .vB_data(vB), .strd(strd),
      .ldr(ldr), .b(b), .wb(wb), .alu(alu), .setcc(setcc), .mem_rw(mem_rw),
      .mem_v(mem_v), .conv_en(conv_en), .out_PC(out_PC), .out_opcode(out_opcode),
      .out_rD(out_rD), .out_strd(out_strd), .out_ldr(out_ldr), .out_wb(out_wb),
      .out_mem_rw(out_mem_rw), .out_mem_v(out_mem_v), .out_result(out_result),
      .out_vresult(out_vresult), .out_store_data(out_store_data),
      .b_taken(b_taken), .b_target(b_target), .stall(stall), .flags(flags)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected $finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      PC = '0; rA = '0; rB = '0; opcode = '0; rD = '0; vA = '0; vB = '0;
      strd = '0; ldr = 0; setcc = 0; mem_rw = 0; mem_v = 0; conv_en = 0;
      b = '0; wb = '0; alu = '0;
   endtask

   task automatic scalar_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                            input logic [31:0] bb, input logic [31:0] exp_res);
      clear_inputs();
      alu = op; rA = a; rB = bb;
      tick();
      check(tag, out_result, exp_res);
   endtask

   task automatic run_conv(input string tag, input logic [127:0] va, input logic [127:0] vb,
                           input logic [31:0] exp_res, input logic [1:0] exp_flags);
      clear_inputs();
      vA = va; vB = vb; conv_en = 1; setcc = 1; rD = 5'd7; wb = 2'd1;
      PC = 32'h200; opcode = 5'd9; b = 2'b01;
      #1;
      check({tag, "_stall_accept"}, stall, 1);
      check({tag, "_btaken_conv"}, b_taken, 0);
      for (int i = 0; i < 5; i++) begin
         tick();
         check({tag, "_stall_busy"}, stall, 1);
         check({tag, "_bubble"}, out_result, 0);
      end
      clear_inputs();
      tick();
      check({tag, "_result"}, out_result, exp_res);
      check({tag, "_flags"}, flags, exp_flags);
      check({tag, "_rd"}, out_rD, 7);
      check({tag, "_pc"}, out_PC, 32'h200);
      check({tag, "_wb_opc"}, {out_wb, out_opcode}, {2'd1, 5'd9});
      check({tag, "_stall_done"}, stall, 0);
   endtask

   initial begin
      clear_inputs();
      rst_n = 1'b0;
      conv_en = 1; b = 2'b01;
      #3;
      check("rst_stall", stall, 0);
      check("rst_btaken", b_taken, 0);
      tick();
      check("rst_result", out_result, 0);
      check("rst_flags", flags, 0);
      check("rst_pc", out_PC, 0);
      clear_inputs();
      rst_n = 1'b1;
      tick();
      check("bubble_after_rst", {out_result, out_PC, out_rD}, 0);
      check("bubble_stall", stall, 0);

      // ADD with wrap, plus all pass-through controls
      clear_inputs();
      alu = 4'd1; rA = 32'hFFFF_FFFF; rB = 32'd2; setcc = 1;
      rD = 5'd3; strd = 3'd5; ldr = 1; wb = 2'd2; mem_rw = 1; mem_v = 1;
      opcode = 5'h11; PC = 32'h40;
      tick();
      check("add_wrap", out_result, 1);
      check("add_flags", flags, 2'b00);
      check("pass_ctrl", {out_rD, out_strd, out_ldr, out_wb, out_mem_rw, out_mem_v, out_opcode},
            {5'd3, 3'd5, 1'b1, 2'd2, 1'b1, 1'b1, 5'h11});
      check("pass_pc", out_PC, 32'h40);
      check("store_data", out_store_data, 2);

      clear_inputs();
      alu = 4'd2; rA = 5; rB = 5; setcc = 1;
      tick();
      check("sub_zero", out_result, 0);
      check("sub_zflag", flags, 2'b01);

      // Branch on Z while the same instruction clears Z
      clear_inputs();
      b = 2'b10; PC = 32'h100; rB = 32'h20; alu = 4'd1; rA = 1; setcc = 1;
      #1;
      check("bz_taken", b_taken, 1);
      check("bz_target", b_target, 32'h120);
      tick();
      check("bz_result", out_result, 32'h21);
      check("bz_flags", flags, 2'b00);
      clear_inputs();
      b = 2'b10;
      #1;
      check("bz_not_taken", b_taken, 0);
      tick();

      clear_inputs();
      alu = 4'd2; rA = 3; rB = 5; setcc = 1;
      tick();
      check("sub_neg", out_result, 32'hFFFF_FFFE);
      check("sub_nflag", flags, 2'b10);
      clear_inputs();
      b = 2'b11;
      #1;
      check("bn_taken", b_taken, 1);
      b = 2'b00;
      #1;
      check("bnone", b_taken, 0);

      scalar_op("shl", 4'd6, 32'd1, 32'd33, 32'd2);
      scalar_op("shr", 4'd7, 32'h8000_0000, 32'd31, 32'd1);
      scalar_op("and", 4'd3, 32'hF0F0, 32'hFF00, 32'hF000);
      scalar_op("or",  4'd4, 32'hF0F0, 32'h0F00, 32'hFFF0);
      scalar_op("xor", 4'd5, 32'hFF, 32'h0F, 32'hF0);
      scalar_op("pass", 4'd0, 32'h1234, 32'hABCD, 32'hABCD);
      scalar_op("alu12", 4'd12, 32'h1234, 32'hABCD, 32'h0);

      clear_inputs();
      alu = 4'd8;
      vA = 128'h0f0e0d0c_0b0a0908_07060504_0302ff7f;
      vB = 128'h10101010_10101010_10101010_10100101;
      tick();
      check("vadd", out_vresult, 128'h1f1e1d1c_1b1a1918_17161514_13120080);
      check("vadd_scalar0", out_result, 0);

      clear_inputs();
      alu = 4'd9; vA = 128'h8000; vB = 128'h0101;
      tick();
      check("vsub", out_vresult, 128'h7fff);

      clear_inputs();
      alu = 4'd10; vA = 128'h05ff80; vB = 128'hfe017f;
      tick();
      check("vmax", out_vresult, 128'h05017f);

      clear_inputs();
      tick();
      check("bubble_vres", out_vresult, 0);
      check("bubble_all", {out_result, out_PC, out_store_data, out_rD, out_wb}, 0);

      run_conv("conv1", {16{8'hFF}}, {16{8'h02}}, 32'hFFFF_FFE0, 2'b10);

      // Abort a conv while it is processing chunk 2
      clear_inputs();
      vA = {16{8'h7F}}; vB = {16{8'h7F}}; conv_en = 1; setcc = 1; rD = 5'd9;
      tick();
      tick();
      tick();
      rst_n = 1'b0;
      #1;
      check("abort_stall", stall, 0);
      check("abort_flags", flags, 0);
      check("abort_outs", {out_result, out_rD}, 0);
      clear_inputs();
      #2;
      rst_n = 1'b1;
      tick();
      check("abort_no_partial", {out_result, out_rD}, 0);
      check("abort_idle", stall, 0);

      run_conv("conv2", 128'h0f0e0d0c_0b0a0908_07060504_03020100, {16{8'hFF}},
               32'hFFFF_FF88, 2'b10);
      run_conv("conv3", {16{8'h7F}}, {16{8'h80}}, 32'hFFFC_0800, 2'b10);
      run_conv("conv4", 128'h0f0e0d0c_0b0a0908_07060504_03020100, {16{8'h01}},
               32'h0000_0078, 2'b00);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
